// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared definitions for the pipeline skid-buffer stage.
//   skid_state_e : occupancy of the 2-entry skid buffer
//                  (EMPTY, ONE = main valid, TWO = main and skid valid).
//   NOP_DEFAULT  : default bubble payload used when a stage holds no entry.
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  localparam logic [15:0] NOP_DEFAULT = 16'h0000;

endpackage : pipe_pkg

// File: rtl/pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot -- one payload register of the skid buffer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear, payload returns to NOP_VAL
//   we_i  : load d_i on the next rising edge
//   d_i   : payload to load
//   q_o   : stored payload
// ---------------------------------------------------------------------------
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W  = 16,
  parameter logic [DATA_W-1:0]   NOP_VAL = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= NOP_VAL;
    end else if (we_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : pipe_skid_slot

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg -- valid/ready pipeline stage built as a 2-entry skid buffer.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data is the payload
//   out_valid/out_ready : downstream handshake, out_data is the payload
//                         (NOP_VAL whenever the stage holds a bubble)
//   flush               : synchronous flush, empties the stage
//   flush_q             : flush delayed one clock for the next stage
//   stall_cnt           : saturating count of stalled cycles
//                         (only when PIPE_SKID_STATS_EN is defined)
// Optional feature macro: PIPE_SKID_STATS_EN.
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned         DATA_W  = 16,
  parameter logic [DATA_W-1:0]   NOP_VAL = DATA_W'(NOP_DEFAULT),
  parameter int unsigned         CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
`ifdef PIPE_SKID_STATS_EN
  output logic              flush_q,
  output logic [CNT_W-1:0]  stall_cnt
`else
  output logic              flush_q
`endif
);

  skid_state_e       state_q, state_d;
  logic              main_we, skid_we;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              flush_q_q;

  // Ready comes straight from registered state so upstream never sees a
  // combinational path from out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_VAL;

  always_comb begin
    state_d = state_q;
    main_we = 1'b0;
    skid_we = 1'b0;
    main_d  = in_data;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          state_d = ST_ONE;
          main_we = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_valid && out_ready) begin
          main_we = 1'b1;
        end else if (in_valid) begin
          // Downstream stalled: park the new entry in the skid slot.
          state_d = ST_TWO;
          skid_we = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          state_d = ST_ONE;
          main_we = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything, including an entry offered this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_we = 1'b0;
      skid_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      flush_q_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_q_q <= flush;
    end
  end

  assign flush_q = flush_q_q;

  pipe_skid_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (main_we),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  pipe_skid_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (skid_we),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int unsigned DATA_W = 16;
  localparam logic [15:0] NOP    = 16'hF000;
  localparam int unsigned CNT_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, flush, flush_q;
  logic [15:0] in_data, out_data;
`ifdef PIPE_SKID_STATS_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  pipe_skid_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
`ifdef PIPE_SKID_STATS_EN
    .flush_q   (flush_q),
    .stall_cnt (stall_cnt)
`else
    .flush_q   (flush_q)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: the stage is a FIFO of at most two accepted entries.
  logic [15:0]      mq[$];
  bit               m_flush_q;
  logic [CNT_W-1:0] m_stall;
  bit               m_rdy, m_ov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_flush_q = 1'b0;
      m_stall   = '0;
    end else begin
      m_rdy = (mq.size() < 2);
      m_ov  = (mq.size() > 0);
      if (m_ov && !out_ready && m_stall != {CNT_W{1'b1}}) m_stall = m_stall + 1'b1;
      m_flush_q = flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_ov && out_ready) void'(mq.pop_front());
        if (in_valid && m_rdy) mq.push_back(in_data);
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
      cmp("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      cmp("out_data",  {16'd0, out_data},  {16'd0, (mq.size() > 0) ? mq[0] : NOP});
      cmp("flush_q",   {31'd0, flush_q},   {31'd0, m_flush_q});
`ifdef PIPE_SKID_STATS_EN
      cmp("stall_cnt", {28'd0, stall_cnt}, {28'd0, m_stall});
`endif
    end
  end

  // Apply one cycle of stimulus; returns shortly after the following negedge.
  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    #2;
    $display("cyc v=%0b d=%h r=%0b f=%0b -> ov=%0b od=%h ir=%0b fq=%0b",
             v, d, r, f, out_valid, out_data, in_ready, flush_q);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    cmp("rst_in_ready",  {31'd0, in_ready},  32'd1);
    cmp("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cmp("rst_out_data",  {16'd0, out_data},  32'h0000_F000);
    cmp("rst_flush_q",   {31'd0, flush_q},   32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Streaming: each word appears one cycle after acceptance.
    drive(1, 16'd1, 1, 0); cmp("stream1", {16'd0, out_data}, 32'd1); cmp("stream_rdy", {31'd0, in_ready}, 32'd1);
    drive(1, 16'd2, 1, 0); cmp("stream2", {16'd0, out_data}, 32'd2);
    drive(1, 16'd3, 1, 0); cmp("stream3", {16'd0, out_data}, 32'd3);
    drive(0, 16'd0, 1, 0); cmp("stream_drain", {31'd0, out_valid}, 32'd0);

    // Skid: A then B while stalled, then drain in order.
    drive(1, 16'hAAAA, 0, 0); cmp("skidA", {16'd0, out_data}, 32'h0000_AAAA);
    drive(1, 16'hBBBB, 0, 0); cmp("skid_full", {31'd0, in_ready}, 32'd0);
                              cmp("skid_holdA", {16'd0, out_data}, 32'h0000_AAAA);
    drive(0, 16'd0, 0, 0);    cmp("skid_stableA", {16'd0, out_data}, 32'h0000_AAAA);
    drive(0, 16'd0, 1, 0);    cmp("skidB", {16'd0, out_data}, 32'h0000_BBBB);
                              cmp("skid_rdy", {31'd0, in_ready}, 32'd1);
    drive(0, 16'd0, 1, 0);    cmp("skid_empty", {31'd0, out_valid}, 32'd0);

    // Flush while full with C offered.
    drive(1, 16'hAAAA, 0, 0);
    drive(1, 16'hBBBB, 0, 0);
    drive(1, 16'hCCCC, 0, 1); cmp("flush_ov", {31'd0, out_valid}, 32'd0);
                              cmp("flush_od", {16'd0, out_data}, 32'h0000_F000);
                              cmp("flush_q1", {31'd0, flush_q}, 32'd1);
    drive(0, 16'd0, 1, 0);    cmp("flush_q0", {31'd0, flush_q}, 32'd0);
                              cmp("flush_gone", {31'd0, out_valid}, 32'd0);
    // Flush in ONE with an entry accepted on the handshake: dropped too.
    drive(1, 16'h1111, 0, 0);
    drive(1, 16'h2222, 1, 1); cmp("flush1_ov", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_SKID_STATS_EN
    drive(1, 16'h0005, 0, 0);
    repeat (20) drive(0, 16'd0, 0, 0);
    cmp("stall_sat", {28'd0, stall_cnt}, 32'd15);
    drive(0, 16'd0, 1, 0);
`endif

    // Asynchronous reset in the middle of a cycle while in ONE.
    drive(1, 16'h5A5A, 0, 0); cmp("pre_rst_ov", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    cmp("arst_ov", {31'd0, out_valid}, 32'd0);
    cmp("arst_ir", {31'd0, in_ready},  32'd1);
    cmp("arst_od", {16'd0, out_data},  32'h0000_F000);
`ifdef PIPE_SKID_STATS_EN
    cmp("arst_stall", {28'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) < 7), 16'($urandom_range(0, 16'hFFFF)),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
    end
    drive(0, 16'd0, 1, 0);
    drive(0, 16'd0, 1, 0);
    cmp("final_empty", {31'd0, out_valid}, 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_skid_reg
